// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//
// Purpose:
//   Byte-stream loader for the writable instruction memory. A session begins
//   with a Start pulse, takes a two-byte big-endian word count N, then N
//   big-endian 32-bit words. Each completed word is written to consecutive
//   word addresses starting at BASE_ADDR. The CPU is held in reset while a
//   load is in progress and stays held if the load aborts, so a partial
//   image never runs.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   Start        one-cycle pulse that begins a load session
//   RxData       received byte
//   RxValid      one-cycle strobe, RxData valid this cycle
//   WriteEnable  one-cycle instruction-memory write strobe
//   WriteAddr    byte address of the write (word aligned)
//   WriteData    instruction word to write
//   CpuHold      high holds the CPU in reset
//   Busy         high while a session is in progress
//   Done         high after a successful load
//   Error        high after an aborted load
//   WordCount    words written in the current or last session
// ---------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int          DEPTH          = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        WriteEnable,
    output logic [31:0] WriteAddr,
    output logic [31:0] WriteData,
    output logic        CpuHold,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] WordCount
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERROR
    } state_t;

    // Value the idle counter holds during the last allowed silent cycle.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state;
    state_t      state_next;
    logic [15:0] word_total;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [31:0] idle_count;

    logic        loading;
    logic        session_start;
    logic        timeout_hit;
    logic        last_write;
    logic [15:0] header_len;

    assign loading       = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign session_start = Start && ((state == IDLE) || (state == DONE) || (state == ERROR));

    // The counter reaches TIMEOUT_CYCLES at the end of this cycle, so the
    // abort lands exactly TIMEOUT_CYCLES silent cycles after the last byte.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && loading && !RxValid &&
                         (idle_count == TIMEOUT_LAST);

    // WordCount is already incremented while the strobe is high, so the
    // final write is the one where it equals the header count.
    assign last_write = WriteEnable && (WordCount == word_total);

    // Full header value as seen while the low byte is on RxData.
    assign header_len = {word_total[15:8], RxData};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs; status is a pure function of
    // the state so it changes in the same cycle as the state does.
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        CpuHold    = 1'b0;
        Done       = 1'b0;
        Error      = 1'b0;

        case (state)
            IDLE, DONE, ERROR: begin
                if (Start) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (RxValid) begin
                    state_next = LEN_LO;
                end else if (timeout_hit) begin
                    state_next = ERROR;
                end
            end
            LEN_LO: begin
                if (RxValid) begin
                    if (header_len == 16'd0) begin
                        state_next = DONE;
                    end else if (32'(header_len) > 32'(DEPTH)) begin
                        state_next = ERROR;
                    end else begin
                        state_next = DATA;
                    end
                end else if (timeout_hit) begin
                    state_next = ERROR;
                end
            end
            DATA: begin
                if (last_write) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = ERROR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        Busy    = loading;
        CpuHold = loading || (state == ERROR);
        Done    = (state == DONE);
        Error   = (state == ERROR);
    end

    // Datapath: header capture, word assembly, write strobe and the idle
    // timer. The first three bytes of a word shift into word_buf; the fourth
    // completes it and issues the write directly from RxData, which is what
    // lets the next word's first byte arrive during the write cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            WriteEnable <= 1'b0;
            WriteAddr   <= BASE_ADDR;
            WriteData   <= 32'd0;
            WordCount   <= 16'd0;
            word_total  <= 16'd0;
            byte_idx    <= 2'd0;
            word_buf    <= 24'd0;
            idle_count  <= 32'd0;
        end else begin
            WriteEnable <= 1'b0;

            if (session_start) begin
                WordCount  <= 16'd0;
                byte_idx   <= 2'd0;
                idle_count <= 32'd0;
            end else if (loading) begin
                if (RxValid) begin
                    idle_count <= 32'd0;
                    case (state)
                        LEN_HI: begin
                            word_total[15:8] <= RxData;
                        end
                        LEN_LO: begin
                            word_total[7:0] <= RxData;
                        end
                        DATA: begin
                            if (byte_idx == 2'd3) begin
                                WriteEnable <= 1'b1;
                                WriteData   <= {word_buf, RxData};
                                WriteAddr   <= BASE_ADDR + {14'd0, WordCount, 2'b00};
                                WordCount   <= WordCount + 16'd1;
                                byte_idx    <= 2'd0;
                            end else begin
                                word_buf <= {word_buf[15:0], RxData};
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end else begin
                    idle_count <= idle_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Purpose:
//   Drives two loader instances from one shared byte stream: dutA with the
//   default depth and timeout, dutB with DEPTH = 4 and TIMEOUT_CYCLES = 20.
//   Expected memory writes are pushed into a queue per instance as the
//   fourth byte of each word is driven and popped as the write strobes
//   appear.
//
// Ports:
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } expWrite_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [7:0]  RxData;
    logic        RxValid;

    logic        weA, holdA, busyA, doneA, errA;
    logic [31:0] addrA, dataA;
    logic [15:0] wcA;
    logic        weB, holdB, busyB, doneB, errB;
    logic [31:0] addrB, dataB;
    logic [15:0] wcB;

    logic [3:0]  statusA, statusB;
    assign statusA = {busyA, doneA, errA, holdA};
    assign statusB = {busyB, doneB, errB, holdB};

    expWrite_t   qA[$];
    expWrite_t   qB[$];
    expWrite_t   eA, eB;
    int unsigned cyc = 0;
    int          mdlK = 0;
    int          total = 0;
    int          bad = 0;

    inst_mem_loader #(.DEPTH(256), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(1000000)) dutA (
        .clk(clk), .reset(reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
        .WriteEnable(weA), .WriteAddr(addrA), .WriteData(dataA), .CpuHold(holdA),
        .Busy(busyA), .Done(doneA), .Error(errA), .WordCount(wcA)
    );

    inst_mem_loader #(.DEPTH(4), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(20)) dutB (
        .clk(clk), .reset(reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
        .WriteEnable(weB), .WriteAddr(addrB), .WriteData(dataB), .CpuHold(holdB),
        .Busy(busyB), .Done(doneB), .Error(errB), .WordCount(wcB)
    );

    // Free-running clock and a cycle counter used to time-stamp writes.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard for dutA: every strobe must match the oldest expected write,
    // including the cycle it was due in.
    always @(negedge clk) begin
        if (weA === 1'b1) begin
            if (qA.size() == 0) begin
                checkOutput("dutA unexpected write", {31'd0, weA}, 32'd0);
            end else begin
                eA = qA.pop_front();
                checkOutput("dutA write addr", addrA, eA.addr);
                checkOutput("dutA write data", dataA, eA.data);
                checkOutput("dutA write cycle", cyc, eA.cyc);
            end
        end
    end

    // Same scoreboard for dutB.
    always @(negedge clk) begin
        if (weB === 1'b1) begin
            if (qB.size() == 0) begin
                checkOutput("dutB unexpected write", {31'd0, weB}, 32'd0);
            end else begin
                eB = qB.pop_front();
                checkOutput("dutB write addr", addrB, eB.addr);
                checkOutput("dutB write data", dataB, eB.data);
                checkOutput("dutB write cycle", cyc, eB.cyc);
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one byte for exactly one cycle; back-to-back calls give
    // bytes on consecutive cycles.
    task automatic applyStimulus(input logic [7:0] b);
        RxData  = b;
        RxValid = 1'b1;
        @(posedge clk);
        #1;
        RxValid = 1'b0;
    endtask

    task automatic pulseStart(input logic withByte);
        Start   = 1'b1;
        RxValid = withByte;
        RxData  = 8'hFF;
        @(posedge clk);
        #1;
        Start   = 1'b0;
        RxValid = 1'b0;
    endtask

    task automatic sendHeader(input logic [15:0] n);
        mdlK = 0;
        applyStimulus(n[15:8]);
        applyStimulus(n[7:0]);
    endtask

    // Sends one word big-endian; the expected write is due the cycle after
    // the fourth byte is presented.
    task automatic loadWord(input logic [31:0] w);
        expWrite_t e;
        applyStimulus(w[31:24]);
        applyStimulus(w[23:16]);
        applyStimulus(w[15:8]);
        e.addr = BASE + 32'(4 * mdlK);
        e.data = w;
        e.cyc  = cyc + 1;
        qA.push_back(e);
        qB.push_back(e);
        mdlK++;
        applyStimulus(w[7:0]);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " statusA"}, {28'd0, statusA}, 32'd0);
        checkOutput({tag, " statusB"}, {28'd0, statusB}, 32'd0);
        checkOutput({tag, " weA"}, {31'd0, weA}, 32'd0);
        checkOutput({tag, " addrA"}, addrA, BASE);
        checkOutput({tag, " dataA"}, dataA, 32'd0);
        checkOutput({tag, " wcA"}, {16'd0, wcA}, 32'd0);
        checkOutput({tag, " wcB"}, {16'd0, wcB}, 32'd0);
    endtask

    task automatic checkDone(input string tag, input logic [15:0] n);
        checkOutput({tag, " statusA"}, {28'd0, statusA}, 32'b0100);
        checkOutput({tag, " statusB"}, {28'd0, statusB}, 32'b0100);
        checkOutput({tag, " wcA"}, {16'd0, wcA}, {16'd0, n});
        checkOutput({tag, " wcB"}, {16'd0, wcB}, {16'd0, n});
    endtask

    // Directed sequence; status vectors read {Busy, Done, Error, CpuHold}.
    initial begin
        Start   = 1'b0;
        RxValid = 1'b0;
        RxData  = 8'h00;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkReset("initial");

        // A byte with no session open must be dropped.
        applyStimulus(8'h00);
        idleCycles(1);
        checkOutput("idle rx statusA", {28'd0, statusA}, 32'd0);
        checkOutput("idle rx statusB", {28'd0, statusB}, 32'd0);

        // Normal load; Start carries a byte that must not become the header.
        pulseStart(1'b1);
        checkOutput("start statusA", {28'd0, statusA}, 32'b1001);
        checkOutput("start statusB", {28'd0, statusB}, 32'b1001);
        sendHeader(16'h0002);
        loadWord(32'h2009_0001);
        pulseStart(1'b0);
        checkOutput("start in data statusA", {28'd0, statusA}, 32'b1001);
        loadWord(32'h200A_0002);
        idleCycles(1);
        checkDone("normal", 16'd2);

        // Back-to-back bytes, filling dutB exactly.
        pulseStart(1'b0);
        sendHeader(16'h0004);
        loadWord(32'h1122_3344);
        loadWord(32'h5566_7788);
        loadWord(32'h99AA_BBCC);
        loadWord(32'hDDEE_FF00);
        idleCycles(1);
        checkDone("b2b", 16'd4);

        // Oversize header for dutB, legal (and left waiting) for dutA.
        pulseStart(1'b0);
        sendHeader(16'h0005);
        checkOutput("oversize statusB", {28'd0, statusB}, 32'b0011);
        checkOutput("oversize wcB", {16'd0, wcB}, 32'd0);
        checkOutput("oversize statusA", {28'd0, statusA}, 32'b1001);
        idleCycles(2);
        doReset();
        checkReset("after oversize");

        // Timeout on dutB: one word, two stray bytes, then silence.
        pulseStart(1'b0);
        sendHeader(16'h0002);
        loadWord(32'hCAFE_F00D);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        idleCycles(19);
        checkOutput("timeout early errB", {31'd0, errB}, 32'd0);
        idleCycles(1);
        checkOutput("timeout statusB", {28'd0, statusB}, 32'b0011);
        checkOutput("timeout wcB", {16'd0, wcB}, 32'd1);
        checkOutput("timeout statusA", {28'd0, statusA}, 32'b1001);
        doReset();

        // Empty image.
        pulseStart(1'b0);
        sendHeader(16'h0000);
        checkDone("empty", 16'd0);

        // Reset in the middle of a word, then a fresh load from BASE.
        pulseStart(1'b0);
        sendHeader(16'h0002);
        loadWord(32'h0BAD_BEEF);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        doReset();
        checkReset("midload");
        pulseStart(1'b0);
        sendHeader(16'h0002);
        loadWord(32'h1357_9BDF);
        loadWord(32'h2468_ACE0);
        idleCycles(1);
        checkDone("reload", 16'd2);

        idleCycles(2);
        checkOutput("pending writes A", 32'(qA.size()), 32'd0);
        checkOutput("pending writes B", 32'(qB.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
